// File: rtl/tcam_pkg.sv
// ---------------------------------------------------------------------------
// tcam_pkg
// Shared definitions for the tcam_d1 ternary CAM.
//   TCAM_MAX_WIDTH : widest key/entry the shared match function handles.
//                    Narrower designs zero-extend their operands, so padded
//                    bits are never "cared" about.
//   tcam_word_t    : a key, value or mask at the maximum width.
//   ternary_match  : the per-entry compare used by every table row.
// The S1->S2 pipeline record depends on SIZE, so the top declares it next to
// its parameters rather than here.
// Optional feature macro (used by the other files): TCAM_MULTIHIT_EN
// ---------------------------------------------------------------------------
package tcam_pkg;

    localparam int TCAM_MAX_WIDTH = 128;

    typedef logic [TCAM_MAX_WIDTH-1:0] tcam_word_t;

    // An entry matches when it is valid and every cared-about bit agrees
    // with the key. An all-zero mask therefore matches any key.
    function automatic logic ternary_match(
        input logic       valid,
        input tcam_word_t key,
        input tcam_word_t value,
        input tcam_word_t mask
    );
        return valid && (((key ^ value) & mask) == '0);
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// ---------------------------------------------------------------------------
// tcam_prio_enc
// Purely combinational priority encoder for the TCAM match vector.
// The lowest set bit wins.
//   i_vec   : N-bit match vector
//   o_index : index of the lowest set bit, 0 when no bit is set
//   o_any   : at least one bit set
//   o_multi : two or more bits set (present only with TCAM_MULTIHIT_EN)
// ---------------------------------------------------------------------------
module tcam_prio_enc #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_index,
    output logic          o_any
`ifdef TCAM_MULTIHIT_EN
    ,
    output logic          o_multi
`endif
);

    // Scan from the top down so the last hit written is the lowest index.
    // Any further hit after the first one seen means at least two matched.
    always_comb begin
        o_index = '0;
        o_any   = 1'b0;
`ifdef TCAM_MULTIHIT_EN
        o_multi = 1'b0;
`endif
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
`ifdef TCAM_MULTIHIT_EN
                if (o_any) begin
                    o_multi = 1'b1;
                end
`endif
                o_index = IW'(i);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcam_d1.sv
// ---------------------------------------------------------------------------
// tcam_d1
// Ternary CAM with SIZE entries of {value, care mask, valid}. A search is
// compared against every entry in parallel (stage S1, match vector
// registered), then priority-encoded (stage S2, results registered), giving
// a two-edge, fully pipelined search with no backpressure.
// Parameters: WIDTH (key bits, <= TCAM_MAX_WIDTH), SIZE (entries, >= 2),
//             INDEX_SIZE (2**INDEX_SIZE >= SIZE).
// Ports:
//   clk, reset (asynchronous, active-low)
//   write_en, write_index, write_data, write_mask, write_valid : table write
//   write_done    : one-cycle acknowledge, one edge after write_en
//   search_go, search_key : launch a search
//   search_done   : one-cycle pulse, two edges after search_go
//   search_hit, search_index : result, held between pulses
//   search_multi  : two or more entries matched (only with TCAM_MULTIHIT_EN)
// Optional feature macro: TCAM_MULTIHIT_EN
// ---------------------------------------------------------------------------
module tcam_d1
    import tcam_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 32,
    parameter int INDEX_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [INDEX_SIZE-1:0] write_index,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [WIDTH-1:0]      write_mask,
    input  logic                  write_valid,
    output logic                  write_done,
    input  logic                  search_go,
    input  logic [WIDTH-1:0]      search_key,
    output logic                  search_done,
    output logic                  search_hit,
    output logic [INDEX_SIZE-1:0] search_index
`ifdef TCAM_MULTIHIT_EN
    ,
    output logic                  search_multi
`endif
);

    // S1 -> S2 pipeline record: stage valid plus the registered match vector.
    typedef struct packed {
        logic            valid;
        logic [SIZE-1:0] match;
    } s1Rec_t;

    logic [WIDTH-1:0]      r_value [SIZE];
    logic [WIDTH-1:0]      r_mask  [SIZE];
    logic [SIZE-1:0]       r_valid;
    s1Rec_t                r_s1;

    logic [SIZE-1:0]       w_match;
    logic [INDEX_SIZE-1:0] w_index;
    logic                  w_any;
`ifdef TCAM_MULTIHIT_EN
    logic                  w_multi;
`endif

    // Zero-extend to the shared match width; padded mask bits are 0 so they
    // never affect the compare.
    function automatic tcam_word_t padWord(input logic [WIDTH-1:0] x);
        tcam_word_t p;
        p            = '0;
        p[WIDTH-1:0] = x;
        return p;
    endfunction

    // Value and mask storage is deliberately not reset; an entry is only
    // meaningful once its valid bit is set, which always comes with a write.
    // An index at or beyond SIZE selects no row, so the table is unchanged.
    always_ff @(posedge clk) begin
        for (int e = 0; e < SIZE; e++) begin
            if (write_en && (write_index == INDEX_SIZE'(e))) begin
                r_value[e] <= write_data;
                r_mask[e]  <= write_mask;
            end
        end
    end

    // Valid bits are the only table state cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            for (int e = 0; e < SIZE; e++) begin
                if (write_en && (write_index == INDEX_SIZE'(e))) begin
                    r_valid[e] <= write_valid;
                end
            end
        end
    end

    // Parallel compare against the table as it stands before the edge, so a
    // search issued alongside a write to the same entry sees the old entry.
    always_comb begin
        w_match = '0;
        for (int e = 0; e < SIZE; e++) begin
            w_match[e] = ternary_match(r_valid[e], padWord(search_key),
                                       padWord(r_value[e]), padWord(r_mask[e]));
        end
    end

    tcam_prio_enc #(
        .N  (SIZE),
        .IW (INDEX_SIZE)
    ) u_prioEnc (
        .i_vec   (r_s1.match),
        .o_index (w_index),
        .o_any   (w_any)
`ifdef TCAM_MULTIHIT_EN
        ,
        .o_multi (w_multi)
`endif
    );

    // Stage S1: capture the match vector for each launched search.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= search_go;
            if (search_go) begin
                r_s1.match <= w_match;
            end
        end
    end

    // Stage S2 and write acknowledge. Results only move when a search
    // completes, so they hold between search_done pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_done   <= 1'b0;
            search_done  <= 1'b0;
            search_hit   <= 1'b0;
            search_index <= '0;
`ifdef TCAM_MULTIHIT_EN
            search_multi <= 1'b0;
`endif
        end else begin
            write_done  <= write_en;
            search_done <= r_s1.valid;
            if (r_s1.valid) begin
                search_hit   <= w_any;
                search_index <= w_index;
`ifdef TCAM_MULTIHIT_EN
                search_multi <= w_multi;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tcam_d1.sv
// ---------------------------------------------------------------------------
// tb_tcam_d1
// Self-checking bench for tcam_d1. A behavioural table model (plain arrays
// and a lowest-index search loop) predicts write_done and the search
// results, which are compared after every clock.
// Optional feature macro: TCAM_MULTIHIT_EN (also checks search_multi)
// ---------------------------------------------------------------------------
module tb_tcam_d1;

    localparam int W  = 32;
    localparam int S  = 32;
    localparam int IS = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_en;
    logic [IS-1:0] write_index;
    logic [W-1:0]  write_data;
    logic [W-1:0]  write_mask;
    logic          write_valid;
    logic          write_done;
    logic          search_go;
    logic [W-1:0]  search_key;
    logic          search_done;
    logic          search_hit;
    logic [IS-1:0] search_index;
`ifdef TCAM_MULTIHIT_EN
    logic          search_multi;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference table and predicted outputs
    logic [W-1:0]  mValue [S];
    logic [W-1:0]  mMask  [S];
    bit            mValid [S];
    bit            pendValid;
    bit            pendHit;
    bit            pendMulti;
    logic [IS-1:0] pendIndex;
    bit            expWriteDone;
    bit            expDone;
    bit            expHit;
    bit            expMulti;
    logic [IS-1:0] expIndex;

    tcam_d1 #(
        .WIDTH      (W),
        .SIZE       (S),
        .INDEX_SIZE (IS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .write_index  (write_index),
        .write_data   (write_data),
        .write_mask   (write_mask),
        .write_valid  (write_valid),
        .write_done   (write_done),
        .search_go    (search_go),
        .search_key   (search_key),
        .search_done  (search_done),
        .search_hit   (search_hit),
        .search_index (search_index)
`ifdef TCAM_MULTIHIT_EN
        ,
        .search_multi (search_multi)
`endif
    );

    always #5 clk = ~clk;

    // Lowest valid entry whose cared-about bits equal the key's.
    function automatic void refSearch(input logic [W-1:0] key, output bit hit,
                                      output logic [IS-1:0] idx, output bit multi);
        int count;
        count = 0;
        idx   = '0;
        for (int e = 0; e < S; e++) begin
            if (mValid[e] && ((key & mMask[e]) == (mValue[e] & mMask[e]))) begin
                if (count == 0) idx = IS'(e);
                count++;
            end
        end
        hit   = (count > 0);
        multi = (count >= 2);
    endfunction

    task automatic modelReset();
        for (int e = 0; e < S; e++) mValid[e] = 1'b0;
        pendValid    = 1'b0;
        expWriteDone = 1'b0;
        expDone      = 1'b0;
        expHit       = 1'b0;
        expMulti     = 1'b0;
        expIndex     = '0;
    endtask

    task automatic applyStimulus();
        write_en    = 1'b0;
        write_index = '0;
        write_data  = '0;
        write_mask  = '0;
        write_valid = 1'b0;
        search_go   = 1'b0;
        search_key  = '0;
    endtask

    // Advance one clock: predict what the DUT registers at this edge, then
    // step to 1 time unit past the edge where outputs are sampled.
    task automatic tick();
        bit            nHit;
        bit            nMulti;
        logic [IS-1:0] nIdx;
        refSearch(search_key, nHit, nIdx, nMulti);
        expWriteDone = write_en;
        expDone      = pendValid;
        if (pendValid) begin
            expHit   = pendHit;
            expIndex = pendIndex;
            expMulti = pendMulti;
        end
        pendValid = search_go;
        if (search_go) begin
            pendHit   = nHit;
            pendIndex = nIdx;
            pendMulti = nMulti;
        end
        if (write_en && (int'(write_index) < S)) begin
            mValue[write_index] = write_data;
            mMask[write_index]  = write_mask;
            mValid[write_index] = write_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input int idx, input logic [W-1:0] val,
                           input logic [W-1:0] msk, input bit vld);
        applyStimulus();
        write_en    = 1'b1;
        write_index = IS'(idx);
        write_data  = val;
        write_mask  = msk;
        write_valid = vld;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        applyStimulus();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        compared++; if (write_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_write_done: got %b expected 0", write_done); end
        compared++; if (search_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_search_done: got %b expected 0", search_done); end
        compared++; if (search_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_search_hit: got %b expected 0", search_hit); end
        compared++; if (search_index !== '0) begin mismatched++; $display("[TB] FAIL reset_search_index: got %0d expected 0", search_index); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        doWrite(3, 32'h0000_00AB, 32'h0000_00FF, 1'b1);
        compared++; if (write_done !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_write_done: got %b expected 1", write_done); end
        applyStimulus();
        search_go  = 1'b1;
        search_key = 32'h1234_56AB;
        tick();
        compared++; if (write_done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_write_done_drop: got %b expected 0", write_done); end
        compared++; if (search_done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_early: got %b expected 0", search_done); end
        applyStimulus();
        tick();
        compared++; if (search_done !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_done: got %b expected 1", search_done); end
        compared++; if (search_hit !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_hit: got %b expected 1", search_hit); end
        compared++; if (search_index !== 5'd3) begin mismatched++; $display("[TB] FAIL basic_index: got %0d expected 3", search_index); end
        applyStimulus();
        tick();
        compared++; if (search_done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", search_done); end
        compared++; if (search_index !== expIndex) begin mismatched++; $display("[TB] FAIL basic_index_hold: got %0d expected %0d", search_index, expIndex); end
    endtask

    task automatic test_priority();
        doWrite(2, 32'h5555_5555, 32'h0000_0000, 1'b1);
        doWrite(5, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
        applyStimulus();
        search_go  = 1'b1;
        search_key = 32'hDEAD_BEEF;
        tick();
        applyStimulus();
        tick();
        compared++; if (search_done !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_done: got %b expected 1", search_done); end
        compared++; if (search_hit !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_hit: got %b expected 1", search_hit); end
        compared++; if (search_index !== 5'd2) begin mismatched++; $display("[TB] FAIL prio_index: got %0d expected 2", search_index); end
`ifdef TCAM_MULTIHIT_EN
        compared++; if (search_multi !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_multi: got %b expected 1", search_multi); end
`endif
    endtask

    task automatic test_invalidate();
        doWrite(2, 32'h5555_5555, 32'h0000_0000, 1'b0);
        applyStimulus();
        search_go  = 1'b1;
        search_key = 32'hDEAD_BEEF;
        tick();
        search_key = 32'h0000_0000;
        tick();
        compared++; if (search_done !== 1'b1) begin mismatched++; $display("[TB] FAIL inval_done: got %b expected 1", search_done); end
        compared++; if (search_hit !== 1'b1) begin mismatched++; $display("[TB] FAIL inval_hit: got %b expected 1", search_hit); end
        compared++; if (search_index !== 5'd5) begin mismatched++; $display("[TB] FAIL inval_index: got %0d expected 5", search_index); end
`ifdef TCAM_MULTIHIT_EN
        compared++; if (search_multi !== 1'b0) begin mismatched++; $display("[TB] FAIL inval_multi: got %b expected 0", search_multi); end
`endif
        applyStimulus();
        tick();
        compared++; if (search_done !== 1'b1) begin mismatched++; $display("[TB] FAIL miss_done: got %b expected 1", search_done); end
        compared++; if (search_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_hit: got %b expected 0", search_hit); end
        compared++; if (search_index !== 5'd0) begin mismatched++; $display("[TB] FAIL miss_index: got %0d expected 0", search_index); end
    endtask

    task automatic test_same_cycle();
        applyStimulus();
        write_en    = 1'b1;
        write_index = 5'd7;
        write_data  = 32'h0F0F_0000;
        write_mask  = 32'hFFFF_0000;
        write_valid = 1'b1;
        search_go   = 1'b1;
        search_key  = 32'h0F0F_1234;
        tick();
        applyStimulus();
        search_go  = 1'b1;
        search_key = 32'h0F0F_1234;
        tick();
        applyStimulus();
        compared++; if (search_done !== 1'b1) begin mismatched++; $display("[TB] FAIL same_old_done: got %b expected 1", search_done); end
        compared++; if (search_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL same_old_hit: got %b expected 0", search_hit); end
        tick();
        compared++; if (search_done !== 1'b1) begin mismatched++; $display("[TB] FAIL same_new_done: got %b expected 1", search_done); end
        compared++; if (search_hit !== 1'b1) begin mismatched++; $display("[TB] FAIL same_new_hit: got %b expected 1", search_hit); end
        compared++; if (search_index !== 5'd7) begin mismatched++; $display("[TB] FAIL same_new_index: got %0d expected 7", search_index); end
    endtask

    task automatic test_back_to_back();
        int doneCount;
        doneCount = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            if (i < 8) begin
                search_go  = 1'b1;
                search_key = (i % 2 == 0) ? 32'h1234_56AB : 32'h0000_0000;
            end
            tick();
            if (search_done === 1'b1) doneCount++;
            if (i > 0) begin
                compared++; if (search_done !== expDone) begin mismatched++; $display("[TB] FAIL b2b_done[%0d]: got %b expected %b", i, search_done, expDone); end
                compared++; if (search_hit !== expHit) begin mismatched++; $display("[TB] FAIL b2b_hit[%0d]: got %b expected %b", i, search_hit, expHit); end
                compared++; if (search_index !== expIndex) begin mismatched++; $display("[TB] FAIL b2b_index[%0d]: got %0d expected %0d", i, search_index, expIndex); end
            end
        end
        compared++; if (doneCount != 8) begin mismatched++; $display("[TB] FAIL b2b_pulses: got %0d expected 8", doneCount); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            applyStimulus();
            write_en    = ($urandom_range(0, 2) == 0);
            write_index = IS'($urandom_range(0, S - 1));
            write_data  = $urandom;
            write_mask  = $urandom & 32'h0000_000F;
            write_valid = ($urandom_range(0, 3) != 0);
            search_go   = $urandom_range(0, 1);
            search_key  = $urandom;
            tick();
            compared++; if (write_done !== expWriteDone) begin mismatched++; $display("[TB] FAIL rnd_write_done[%0d]: got %b expected %b", i, write_done, expWriteDone); end
            compared++; if (search_done !== expDone) begin mismatched++; $display("[TB] FAIL rnd_done[%0d]: got %b expected %b", i, search_done, expDone); end
            compared++; if (search_hit !== expHit) begin mismatched++; $display("[TB] FAIL rnd_hit[%0d]: got %b expected %b", i, search_hit, expHit); end
            compared++; if (search_index !== expIndex) begin mismatched++; $display("[TB] FAIL rnd_index[%0d]: got %0d expected %0d", i, search_index, expIndex); end
`ifdef TCAM_MULTIHIT_EN
            compared++; if (search_multi !== expMulti) begin mismatched++; $display("[TB] FAIL rnd_multi[%0d]: got %b expected %b", i, search_multi, expMulti); end
`endif
        end
        applyStimulus();
        tick();
        tick();
    endtask

    task automatic test_reset_inflight();
        int doneSeen;
        doneSeen = 0;
        doWrite(3, 32'h0000_00AB, 32'h0000_00FF, 1'b1);
        applyStimulus();
        search_go  = 1'b1;
        search_key = 32'h1234_56AB;
        tick();
        applyStimulus();
        reset = 1'b0;
        modelReset();
        #1;
        if (search_done === 1'b1) doneSeen++;
        compared++; if (search_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_hit: got %b expected 0", search_hit); end
        compared++; if (search_index !== 5'd0) begin mismatched++; $display("[TB] FAIL rst_index: got %0d expected 0", search_index); end
        @(posedge clk);
        #1;
        if (search_done === 1'b1) doneSeen++;
        reset = 1'b1;
        repeat (3) begin
            tick();
            if (search_done === 1'b1) doneSeen++;
        end
        compared++; if (doneSeen != 0) begin mismatched++; $display("[TB] FAIL rst_dropped: got %0d pulses expected 0", doneSeen); end
        search_go  = 1'b1;
        search_key = 32'h1234_56AB;
        tick();
        applyStimulus();
        tick();
        compared++; if (search_done !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_after_done: got %b expected 1", search_done); end
        compared++; if (search_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_after_hit: got %b expected 0", search_hit); end
        compared++; if (search_hit !== expHit) begin mismatched++; $display("[TB] FAIL rst_after_model: got %b expected %b", search_hit, expHit); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_invalidate();
        test_same_cycle();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
